// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter width for a given number of chunks, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic c;

  always_comb begin
    c     = ci;
    c_msb = 1'b0;
    s     = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      if (i == int'(CHUNK) - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle with a valid/ready handshake
// on both the operand and the result side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam int unsigned IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]    base;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co, chunk_cmsb;
  logic             last;

  assign base = IW'(cnt_q) * IW'(CHUNK);
  assign last = (cnt_q == CW'(NCHUNK - 1));

  chunk_adder #(
    .CHUNK(CHUNK)
  ) u_chunk_adder (
    .x    (a_q[base +: CHUNK]),
    .y    (b_q[base +: CHUNK]),
    .ci   (carry_q),
    .s    (chunk_s),
    .co   (chunk_co),
    .c_msb(chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is folded into the operands: a + ~b + 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        sum_d[base +: CHUNK] = chunk_s;
        carry_d              = chunk_co;
        if (last) begin
          cout_d  = chunk_co;
          ovf_d   = chunk_co ^ chunk_cmsb;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (CHUNK = 4, 16, 1) checked against
// hand vectors and an integer-arithmetic reference model.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin, sub;

  logic        in_valid_w [3];
  logic        out_ready_w[3];
  logic        in_ready_w [3];
  logic        out_valid_w[3];
  logic        cout_w     [3];
  logic        ovf_w      [3];
  logic [15:0] sum_w      [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned C = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    serial_adder #(
      .WIDTH(16),
      .CHUNK(C)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_w[g]),
      .in_ready (in_ready_w[g]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .sub      (sub),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready_w[g]),
      .sum      (sum_w[g]),
      .cout     (cout_w[g]),
      .overflow (ovf_w[g])
    );
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    bit          all_chunks;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                       input logic si, output logic [15:0] s, output logic co,
                       output logic ov);
    int sa, sb, r, u;
    sa = $signed(ai);
    sb = $signed(bi);
    if (si) begin
      r  = sa - sb;
      co = (ai >= bi);
    end else begin
      r  = sa + sb + int'(ci);
      u  = int'(ai) + int'(bi) + int'(ci);
      co = (u > 65535);
    end
    s  = r[15:0];
    ov = (r > 32767) || (r < -32768);
  endtask

  task automatic launch(input int d, input logic [15:0] ai, input logic [15:0] bi,
                        input logic ci, input logic si);
    int n = 0;
    @(negedge clk);
    while (!in_ready_w[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_launch", 32'(in_ready_w[d]), 32'd1);
    a = ai; b = bi; cin = ci; sub = si;
    in_valid_w[d] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_w[d] = 1'b0;
    // Scramble operands while busy; they must not matter.
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!out_valid_w[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input int d);
    @(negedge clk);
    out_ready_w[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_w[d] = 1'b0;
  endtask

  task automatic do_op(input int d, input logic [15:0] ai, input logic [15:0] bi,
                       input logic ci, input logic si, output logic [15:0] s,
                       output logic co, output logic ov, output int lat);
    launch(d, ai, bi, ci, si);
    wait_valid(d, lat);
    s  = sum_w[d];
    co = cout_w[d];
    ov = ovf_w[d];
    handoff(d);
  endtask

  int lat_exp[3] = '{4, 1, 16};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [15:0] s, es, hold_s;
    logic        co, ov, eco, eov, hold_co, hold_ov;
    logic [15:0] ra, rb;
    logic        rc, rs;
    int          lat, rises;

    for (int i = 0; i < 3; i++) begin
      in_valid_w[i]  = 1'b0;
      out_ready_w[i] = 1'b0;
    end
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    rst = 1'b1;

    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(in_ready_w[d]), 32'd0);
      chk("rst_out_valid", 32'(out_valid_w[d]), 32'd0);
    end
    chk("rst_sum", 32'(sum_w[0]), 32'd0);
    chk("rst_cout", 32'(cout_w[0]), 32'd0);
    chk("rst_ovf", 32'(ovf_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("in_ready_after_rst", 32'(in_ready_w[d]), 32'd1);

    // Directed vectors, all chunk sizes for the first three
    for (int d = 0; d < 3; d++) begin
      foreach (vecs[i]) begin
        if (d == 0 || vecs[i].all_chunks) begin
          do_op(d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, lat);
          chk($sformatf("vec%0d_d%0d_sum", i, d), 32'(s), 32'(vecs[i].sum));
          chk($sformatf("vec%0d_d%0d_cout", i, d), 32'(co), 32'(vecs[i].cout));
          chk($sformatf("vec%0d_d%0d_ovf", i, d), 32'(ov), 32'(vecs[i].ovf));
          chk($sformatf("vec%0d_d%0d_latency", i, d), 32'(lat), 32'(lat_exp[d]));
        end
      end
    end

    // Randomized operations against the reference model
    for (int n = 0; n < 60; n++) begin
      int d;
      d  = (n < 40) ? 0 : ((n < 50) ? 1 : 2);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (n % 7 == 0) rb = ra;
      model(ra, rb, rc, rs, es, eco, eov);
      do_op(d, ra, rb, rc, rs, s, co, ov, lat);
      chk($sformatf("rand%0d_sum", n), 32'(s), 32'(es));
      chk($sformatf("rand%0d_cout", n), 32'(co), 32'(eco));
      chk($sformatf("rand%0d_ovf", n), 32'(ov), 32'(eov));
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(lat_exp[d]));
    end

    // Backpressure: hold result for 10 cycles while inputs churn
    model(16'h4321, 16'h1111, 1'b1, 1'b0, es, eco, eov);
    launch(0, 16'h4321, 16'h1111, 1'b1, 1'b0);
    wait_valid(0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    hold_s = sum_w[0]; hold_co = cout_w[0]; hold_ov = ovf_w[0];
    chk("bp_sum", 32'(hold_s), 32'(es));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      in_valid_w[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_sum", 32'(sum_w[0]), 32'(hold_s));
      chk("bp_hold_cout", 32'(cout_w[0]), 32'(hold_co));
      chk("bp_hold_ovf", 32'(ovf_w[0]), 32'(hold_ov));
      chk("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
    end
    @(negedge clk);
    in_valid_w[0] = 1'b0;
    handoff(0);
    chk("bp_release_out_valid", 32'(out_valid_w[0]), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready_w[0]), 32'd1);

    // Reset two chunks into an operation abandons it
    launch(0, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready_w[0]), 32'd0);
    chk("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_after", 32'(in_ready_w[0]), 32'd1);
    chk("midrst_sum_cleared", 32'(sum_w[0]), 32'd0);
    rises = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid_w[0]) rises++;
    end
    chk("midrst_no_out_valid", 32'(rises), 32'd0);
    do_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, s, co, ov, lat);
    chk("post_rst_sum", 32'(s), 32'h2345);
    chk("post_rst_cout", 32'(co), 32'd0);
    chk("post_rst_latency", 32'(lat), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
